// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear; head word is visible as soon as count is non-zero.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count,
    output logic             o_empty,
    output logic             o_full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_empty = (count_reg == '0);
    assign o_full  = (count_reg == CW'(DEPTH));
    assign o_count = count_reg;
    assign o_head  = mem_reg[rd_ptr_reg];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push && !i_clear && !i_reset) mem_reg[wr_ptr_reg] <= i_push_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues in-order memory requests under a credit
// limit, discards responses made stale by redirects and queues {pc, instr} for IF/ID.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_stall,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_instr,
    output logic            o_vld
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc_reg, pc_next;
    logic [CW-1:0]   out_cnt_reg, out_cnt_next;
    logic [CW-1:0]   kill_cnt_reg, kill_cnt_next;
    logic [CW:0]     credit_used;
    logic            grant;
    logic            rsp;
    logic            iq_push;
    logic            iq_pop;

    logic [XLEN-1:0] pcq_head;
    logic [CW-1:0]   pcq_count;
    logic            pcq_empty, pcq_full;
    logic [$bits(fetch_entry_t)-1:0] iq_head_bits;
    fetch_entry_t    iq_head, iq_push_entry;
    logic [CW-1:0]   q_cnt;
    logic            iq_empty, iq_full;
    logic            status_unused;

    // Credit counts only registered state, so a pop frees a slot one cycle later.
    assign credit_used = {1'b0, out_cnt_reg} + {1'b0, q_cnt};
    assign o_imem_req  = !i_reset && !i_redirect && (credit_used < (CW + 1)'(DEPTH));
    assign o_imem_addr = pc_reg;
    assign grant       = o_imem_req && i_imem_gnt;
    assign rsp         = i_imem_rvalid && (out_cnt_reg != '0);

    assign iq_push       = rsp && (kill_cnt_reg == '0) && !i_redirect;
    assign iq_push_entry = '{pc: pcq_head, instr: i_imem_rdata};
    assign iq_pop        = o_vld && !i_stall;
    assign iq_head       = fetch_entry_t'(iq_head_bits);

    assign o_vld   = !iq_empty && !i_redirect && !i_reset;
    assign o_pc    = o_vld ? iq_head.pc    : '0;
    assign o_instr = o_vld ? iq_head.instr : NOP_INSTR;

    assign status_unused = ^{pcq_count, pcq_empty, pcq_full, iq_full};

    always_comb begin
        out_cnt_next  = out_cnt_reg;
        kill_cnt_next = kill_cnt_reg;
        pc_next       = pc_reg;
        if (grant) out_cnt_next = out_cnt_next + CW'(1);
        if (rsp)   out_cnt_next = out_cnt_next - CW'(1);
        // A redirect kills everything still in flight after this cycle's response.
        if (i_redirect) begin
            kill_cnt_next = rsp ? out_cnt_reg - CW'(1) : out_cnt_reg;
            pc_next       = {i_redirect_pc[XLEN-1:2], 2'b00};
        end else begin
            if (rsp && (kill_cnt_reg != '0)) kill_cnt_next = kill_cnt_reg - CW'(1);
            if (grant) pc_next = pc_reg + XLEN'(4);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_reg       <= RESET_PC;
            out_cnt_reg  <= '0;
            kill_cnt_reg <= '0;
        end else begin
            pc_reg       <= pc_next;
            out_cnt_reg  <= out_cnt_next;
            kill_cnt_reg <= kill_cnt_next;
        end
    end

    // Killed requests still occupy the PC queue so responses stay aligned.
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_queue (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (1'b0),
        .i_push      (grant),
        .i_push_data (pc_reg),
        .i_pop       (rsp),
        .o_head      (pcq_head),
        .o_count     (pcq_count),
        .o_empty     (pcq_empty),
        .o_full      (pcq_full)
    );

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_queue (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (i_redirect),
        .i_push      (iq_push),
        .i_push_data (iq_push_entry),
        .i_pop       (iq_pop),
        .o_head      (iq_head_bits),
        .o_count     (q_cnt),
        .o_empty     (iq_empty),
        .o_full      (iq_full)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed checks of fetch_stage against a queue-based reference model.
module tb_fetch_stage;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic        clk;
    logic        rst, stall, redir, gnt, rvalid;
    logic [31:0] rdpc, rdata;
    logic        req, ovld;
    logic [31:0] addr, opc, oinstr;

    fetch_stage #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_stall       (stall),
        .i_redirect    (redir),
        .i_redirect_pc (rdpc),
        .o_imem_req    (req),
        .o_imem_addr   (addr),
        .i_imem_gnt    (gnt),
        .i_imem_rvalid (rvalid),
        .i_imem_rdata  (rdata),
        .o_pc          (opc),
        .o_instr       (oinstr),
        .o_vld         (ovld)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { logic [31:0] pc; bit killed; } infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    infl_t infl_q[$];
    ent_t  iq_q[$];
    mreq_t mem_q[$];
    logic [31:0] mpc;
    logic [31:0] granted[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int lat = 1;
    int gnt_pct = 100;
    bit gnt_en = 1'b1;

    logic        s_req, s_vld;
    logic [31:0] s_addr, s_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // One clock: drive memory side, check outputs against the model, advance the model.
    task automatic run_cycle();
        bit          exp_req, exp_vld;
        logic [31:0] exp_pc, exp_instr;
        infl_t       e;
        rvalid = 1'b0;
        rdata  = $urandom();
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            rvalid = 1'b1;
            rdata  = mem_q[0].addr ^ KEY;
        end
        gnt = gnt_en && ($urandom_range(0, 99) < gnt_pct);
        #1;
        exp_req   = !rst && !redir && (infl_q.size() + iq_q.size() < DEPTH);
        exp_vld   = !rst && !redir && (iq_q.size() != 0);
        exp_pc    = exp_vld ? iq_q[0].pc : 32'h0;
        exp_instr = exp_vld ? iq_q[0].instr : NOP;
        chk("req", {31'b0, req}, {31'b0, exp_req});
        if (!rst) chk("addr", addr, mpc);
        chk("vld", {31'b0, ovld}, {31'b0, exp_vld});
        chk("pc", opc, exp_pc);
        chk("instr", oinstr, exp_instr);
        s_req = req; s_vld = ovld; s_addr = addr; s_pc = opc;
        if (req && gnt) granted.push_back(addr);

        if (rvalid) void'(mem_q.pop_front());
        if (rst) begin
            mpc = RST_PC;
            infl_q.delete();
            iq_q.delete();
        end else begin
            if (exp_vld && !stall) begin
                $display("pop  cyc=%0d pc=%h instr=%h", cyc, iq_q[0].pc, iq_q[0].instr);
                void'(iq_q.pop_front());
            end
            if (rvalid && infl_q.size() > 0) begin
                e = infl_q.pop_front();
                if (!e.killed && !redir) iq_q.push_back('{e.pc, e.pc ^ KEY});
            end
            if (redir) begin
                iq_q.delete();
                foreach (infl_q[k]) infl_q[k].killed = 1'b1;
                mpc = {rdpc[31:2], 2'b00};
            end else if (exp_req && gnt) begin
                infl_q.push_back('{mpc, 1'b0});
                mem_q.push_back('{mpc, cyc + lat});
                mpc = mpc + 32'd4;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    // Run until the DUT shows a valid head; returns cycles taken and the head PC.
    task automatic wait_vld(input int budget, output int n, output logic [31:0] pc, output bit found);
        found = 1'b0; n = 0; pc = 32'h0;
        while (!found && n < budget) begin
            run_cycle();
            n++;
            if (s_vld) begin found = 1'b1; pc = s_pc; end
        end
    endtask

    int          n;
    logic [31:0] pc_seen;
    bit          found;
    logic [31:0] held_pc;

    initial begin
        rst = 1'b1; stall = 1'b0; redir = 1'b0; rdpc = 32'h0;
        gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        mpc = RST_PC;
        @(negedge clk);

        // Reset and 1-cycle memory streaming
        repeat (3) run_cycle();
        chk("rst_req", {31'b0, s_req}, 32'd0);
        chk("rst_vld", {31'b0, s_vld}, 32'd0);
        rst = 1'b0;
        granted.delete();
        repeat (20) run_cycle();
        chk("first_addr0", granted[0], 32'h0);
        chk("first_addr1", granted[1], 32'h4);
        chk("first_addr2", granted[2], 32'h8);
        $display("txn  stream: %0d requests granted", granted.size());

        // Stall with full queue
        stall = 1'b1;
        repeat (3) run_cycle();
        held_pc = s_pc;
        repeat (2) run_cycle();
        chk("stall_req", {31'b0, s_req}, 32'd0);
        chk("stall_vld", {31'b0, s_vld}, 32'd1);
        chk("stall_hold_pc", s_pc, held_pc);
        stall = 1'b0;
        repeat (10) run_cycle();
        $display("txn  stall released");

        // 3-cycle latency, redirect to 0x100 with requests in flight
        lat = 3;
        n = 0;
        while (infl_q.size() < 2 && n < 20) begin run_cycle(); n++; end
        chk("inflight_two", infl_q.size(), 2);
        redir = 1'b1; rdpc = 32'h0000_0100;
        run_cycle();
        redir = 1'b0;
        wait_vld(30, n, pc_seen, found);
        chk("redir100_seen", {31'b0, found}, 32'd1);
        chk("redir100_pc", pc_seen, 32'h0000_0100);
        $display("txn  redirect 0x100 -> valid after %0d cycles", n);

        // Redirect coinciding with a response
        lat = 1;
        n = 0;
        while (!(mem_q.size() > 0 && mem_q[0].due <= cyc) && n < 20) begin run_cycle(); n++; end
        redir = 1'b1; rdpc = 32'h0000_0200;
        run_cycle();
        redir = 1'b0;
        chk("redir_rsp_vld", {31'b0, s_vld}, 32'd0);
        wait_vld(20, n, pc_seen, found);
        chk("redir200_lat", n, 3);
        chk("redir200_pc", pc_seen, 32'h0000_0200);
        $display("txn  redirect 0x200 with response -> valid after %0d cycles", n);

        // PC wrap; low target bits are ignored
        redir = 1'b1; rdpc = 32'hFFFF_FFFD;
        run_cycle();
        redir = 1'b0;
        run_cycle();
        chk("wrap_addr", s_addr, 32'hFFFF_FFFC);
        chk("wrap_req", {31'b0, s_req}, 32'd1);
        run_cycle();
        chk("wrap_next", s_addr, 32'h0000_0000);
        repeat (6) run_cycle();
        $display("txn  pc wrap");

        // Reset with requests outstanding; late responses must be ignored
        lat = 3;
        n = 0;
        while (infl_q.size() < 2 && n < 20) begin run_cycle(); n++; end
        chk("rst_inflight_two", infl_q.size(), 2);
        rst = 1'b1; gnt_en = 1'b0;
        run_cycle();
        chk("midrst_vld", {31'b0, s_vld}, 32'd0);
        chk("midrst_req", {31'b0, s_req}, 32'd0);
        rst = 1'b0;
        n = 0;
        while (mem_q.size() > 0 && n < 10) begin
            run_cycle();
            chk("late_rsp_vld", {31'b0, s_vld}, 32'd0);
            n++;
        end
        chk("late_drained", mem_q.size(), 0);
        gnt_en = 1'b1; lat = 1;
        wait_vld(10, n, pc_seen, found);
        chk("restart_seen", {31'b0, found}, 32'd1);
        chk("restart_pc", pc_seen, RST_PC);
        $display("txn  reset mid-stream, restart at %h", pc_seen);

        // Randomized traffic
        gnt_pct = 70;
        for (int i = 0; i < 600; i++) begin
            stall = ($urandom_range(0, 99) < 30);
            redir = ($urandom_range(0, 99) < 4);
            rdpc  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom();
            rst   = ($urandom_range(0, 199) == 0);
            lat   = $urandom_range(1, 4);
            run_cycle();
        end
        rst = 1'b0; redir = 1'b0; stall = 1'b0;
        repeat (10) run_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
